egress_rr_arbiter: RTL and testbench

Packet-granular round-robin arbiter that shares the single egress AXIS port among NUM_PORTS filtered ingress streams. Each stream is an input_fsm/filter chain followed by its FIFO. A grant is held from the first beat until the tlast handshake, so frames are never interleaved. A beat watchdog truncates runaway frames, and per-port forwarded-packet counters are exposed to software.

---
 rtl/pkt_filter_pkg.sv | 26 ++
 rtl/egress_rr_arbiter_rr_pick.sv | 36 +++
 rtl/egress_rr_arbiter.sv | 138 +++++++++++++
 tb/tb_egress_rr_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_filter_pkg.sv
// Shared stream types and arbiter state encoding for the packet filter datapath.
package pkt_filter_pkg;

  typedef struct packed {
    logic        tvalid;
    logic [15:0] tdata;
    logic        tlast;
  } axis_source_t;

  typedef struct packed {
    logic tready;
  } axis_sink_t;

  typedef enum logic [1:0] {
    FRAME_OK    = 2'b00,
    FRAME_TRUNC = 2'b01,
    FRAME_ABORT = 2'b10
  } frame_status;

  typedef enum logic [1:0] {
    ARB  = 2'b00,
    FWD  = 2'b01,
    DROP = 2'b10
  } arb_state_t;

endpackage

// File: rtl/egress_rr_arbiter_rr_pick.sv
// Round-robin pick: rotate requests so the port after 'last' sits at bit 0,
// priority-encode the lowest set bit, then rotate the index back.
module rr_pick #(
  parameter int NUM_PORTS = 4
) (
  input  logic [NUM_PORTS-1:0]         req,
  input  logic [$clog2(NUM_PORTS)-1:0] last,
  output logic [NUM_PORTS-1:0]         pick,
  output logic [$clog2(NUM_PORTS)-1:0] pick_idx,
  output logic                         found
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [NUM_PORTS-1:0] rot;
  logic [IDX_W-1:0]     enc;

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_PORTS);
  endfunction

  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      rot[i] = req[wrap_idx(int'(last) + 1 + i)];
    end
    enc = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    found    = |rot;
    pick_idx = wrap_idx(int'(last) + 1 + int'(enc));
    pick     = found ? (NUM_PORTS'(1) << pick_idx) : '0;
  end

endmodule

// File: rtl/egress_rr_arbiter.sv
// Packet-granular round-robin arbiter onto one egress stream, with a beat
// watchdog that truncates runaway frames and per-port forwarded-frame counters.
module egress_rr_arbiter
  import pkt_filter_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int MAX_BEATS = 768,
  parameter int CNT_W     = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  axis_source_t [NUM_PORTS-1:0] ingress_sources,
  output axis_sink_t   [NUM_PORTS-1:0] ingress_sinks,
  output axis_source_t                 egress_source,
  input  axis_sink_t                   egress_sink,
  input  logic [NUM_PORTS-1:0]         port_enable,
  input  logic                         count_clear,
  output logic [NUM_PORTS-1:0]         grant,
  output logic                         busy,
  output logic                         trunc_pulse,
  output logic [NUM_PORTS*CNT_W-1:0]   pkt_count
);

  localparam int IDX_W  = $clog2(NUM_PORTS);
  localparam int BEAT_W = $clog2(MAX_BEATS + 1);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(MAX_BEATS - 1);

  arb_state_t           state_q, state_d;
  logic [NUM_PORTS-1:0] grant_q, eligible, pick;
  logic [IDX_W-1:0]     gidx_q, last_q, pick_idx;
  logic                 found;
  logic [BEAT_W-1:0]    beat_q;
  logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
  axis_source_t         sel;
  logic                 hs, wd_beat, pkt_done, wd_hit, drop_end;

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      eligible[i] = ingress_sources[i].tvalid & port_enable[i];
    end
  end

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req      (eligible),
    .last     (last_q),
    .pick     (pick),
    .pick_idx (pick_idx),
    .found    (found)
  );

  // Forced tlast is shown for the whole last-allowed beat, not only on its handshake.
  always_comb begin
    sel      = ingress_sources[gidx_q];
    hs       = (state_q == FWD) && sel.tvalid && egress_sink.tready;
    wd_beat  = (state_q == FWD) && (beat_q == LAST_BEAT);
    pkt_done = hs && sel.tlast;
    wd_hit   = hs && !sel.tlast && wd_beat;
    drop_end = (state_q == DROP) && sel.tvalid && sel.tlast;
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= ARB;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ARB:     if (found) state_d = FWD;
      FWD:     if (pkt_done) state_d = ARB;
               else if (wd_hit) state_d = DROP;
      DROP:    if (drop_end) state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_comb begin
    egress_source = '0;
    ingress_sinks = '0;
    trunc_pulse   = 1'b0;
    case (state_q)
      FWD: begin
        egress_source                = sel;
        egress_source.tlast          = sel.tlast | wd_beat;
        ingress_sinks[gidx_q].tready = egress_sink.tready;
        trunc_pulse                  = wd_hit;
      end
      DROP:    ingress_sinks[gidx_q].tready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IDX_W'(NUM_PORTS - 1);
      beat_q  <= '0;
    end else begin
      case (state_q)
        ARB: if (found) begin
          grant_q <= pick;
          gidx_q  <= pick_idx;
          last_q  <= pick_idx;
          beat_q  <= '0;
        end
        FWD: begin
          if (hs)       beat_q  <= beat_q + BEAT_W'(1);
          if (pkt_done) grant_q <= '0;
        end
        DROP:    if (drop_end) grant_q <= '0;
        default: ;
      endcase
    end
  end

  // A clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (reset || count_clear)
        cnt_q[i] <= '0;
      else if (pkt_done && (gidx_q == IDX_W'(i)))
        cnt_q[i] <= cnt_q[i] + CNT_W'(1);
    end
  end

  always_comb begin
    pkt_count = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pkt_count[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end

  assign grant = grant_q;
  assign busy  = (state_q != ARB);

endmodule

// File: tb/tb_egress_rr_arbiter.sv
// Bench for egress_rr_arbiter: per-port beat queues feed the DUT, a queue of
// expected egress beats is checked on every egress handshake.
module tb_egress_rr_arbiter;
  import pkt_filter_pkg::*;

  localparam int NP   = 4;
  localparam int MAXB = 768;
  localparam int CW   = 16;

  logic                  clk = 1'b0;
  logic                  reset;
  axis_source_t [NP-1:0] src;
  axis_sink_t   [NP-1:0] snk;
  axis_source_t          eg_src;
  axis_sink_t            eg_snk;
  logic [NP-1:0]         port_enable;
  logic                  count_clear;
  logic [NP-1:0]         grant;
  logic                  busy;
  logic                  trunc_pulse;
  logic [NP*CW-1:0]      pkt_count;

  always #5 clk = ~clk;

  egress_rr_arbiter #(.NUM_PORTS(NP), .MAX_BEATS(MAXB), .CNT_W(CW)) dut (
    .clk             (clk),
    .reset           (reset),
    .ingress_sources (src),
    .ingress_sinks   (snk),
    .egress_source   (eg_src),
    .egress_sink     (eg_snk),
    .port_enable     (port_enable),
    .count_clear     (count_clear),
    .grant           (grant),
    .busy            (busy),
    .trunc_pulse     (trunc_pulse),
    .pkt_count       (pkt_count)
  );

  typedef logic [16:0] beat_t;
  typedef struct packed {
    logic [NP-1:0] gnt;
    logic          last;
    logic [15:0]   data;
  } exp_t;
  typedef struct {
    logic [NP-1:0] vmask;
    logic [NP-1:0] emask;
    logic [NP-1:0] gnt;
  } vec_t;

  beat_t pq [NP][$];
  exp_t  exp_q [$];
  logic  rdy_q [$];
  int    eg_cyc [$];
  int    checks = 0, errors = 0, cyc = 0, eg_cnt = 0, trunc_cnt = 0;
  bit    mirror_chk = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [CW-1:0] cnt(input int p);
    return pkt_count[p*CW +: CW];
  endfunction

  task automatic drive_ports();
    for (int p = 0; p < NP; p++) begin
      if (pq[p].size() > 0) begin
        src[p].tvalid = 1'b1;
        src[p].tdata  = pq[p][0][15:0];
        src[p].tlast  = pq[p][0][16];
      end else begin
        src[p] = '0;
      end
    end
  endtask

  task automatic add_frame(input int p, input int n, input logic [15:0] base);
    for (int i = 0; i < n; i++) pq[p].push_back({(i == n - 1), base + 16'(i)});
  endtask

  task automatic expect_frame(input int n, input logic [15:0] base, input logic [NP-1:0] g);
    for (int i = 0; i < n; i++) exp_q.push_back('{gnt: g, last: (i == n - 1), data: base + 16'(i)});
  endtask

  // One clock: sample at the falling edge, update stimulus just after the rising edge.
  task automatic step();
    logic [NP-1:0] hs;
    @(negedge clk);
    for (int p = 0; p < NP; p++) hs[p] = src[p].tvalid & snk[p].tready;
    if (eg_src.tvalid && eg_snk.tready) begin
      eg_cnt++;
      eg_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected actual=%0h required=none", {eg_src.tlast, eg_src.tdata});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_beat", {grant, eg_src.tlast, eg_src.tdata}, {e.gnt, e.last, e.data});
      end
    end
    if (trunc_pulse) trunc_cnt++;
    if (mirror_chk && grant == 4'b1000) chk("tready_mirror", snk[3].tready, eg_snk.tready);
    @(posedge clk);
    #1;
    cyc++;
    for (int p = 0; p < NP; p++) if (hs[p] && pq[p].size() > 0) void'(pq[p].pop_front());
    eg_snk.tready = (rdy_q.size() > 0) ? rdy_q.pop_front() : 1'b1;
    drive_ports();
  endtask

  task automatic wait_done(input string name, input int bound, input bit need_ports);
    int n;
    bit pend;
    n = 0;
    forever begin
      pend = busy || (exp_q.size() > 0);
      if (need_ports) for (int p = 0; p < NP; p++) pend |= (pq[p].size() > 0);
      if (!pend) break;
      if (n == bound) begin
        checks++;
        errors++;
        $display("FAIL %s timeout expected_left=%0d required=0", name, exp_q.size());
        exp_q.delete();
        break;
      end
      step();
      n++;
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vec_t vt [9];
    int   n, w;

    reset = 1'b1;
    count_clear = 1'b0;
    port_enable = '1;
    src = '0;
    eg_snk.tready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_trunc", trunc_pulse, 0);
    chk("rst_count", pkt_count, 0);
    chk("rst_in_tready", snk, 0);
    chk("rst_eg_valid", eg_src.tvalid, 0);
    chk("rst_eg_last", eg_src.tlast, 0);
    reset = 1'b0;

    // Two contending frames: port 0 first, one bubble, then port 2.
    add_frame(0, 3, 16'h0100);
    add_frame(2, 3, 16'h0200);
    expect_frame(3, 16'h0100, 4'b0001);
    expect_frame(3, 16'h0200, 4'b0100);
    eg_cyc.delete();
    drive_ports();
    wait_done("t1_drain", 40, 1);
    chk("t1_beats", eg_cyc.size(), 6);
    if (eg_cyc.size() >= 6) chk("t1_bubble", eg_cyc[3] - eg_cyc[2], 2);
    chk("t1_count0", cnt(0), 1);
    chk("t1_count2", cnt(2), 1);

    // Arbitration vectors, last grant = port 2 on entry.
    vt[0] = '{4'b1111, 4'b1111, 4'b1000};
    vt[1] = '{4'b1111, 4'b1111, 4'b0001};
    vt[2] = '{4'b1001, 4'b1111, 4'b1000};
    vt[3] = '{4'b0110, 4'b1111, 4'b0010};
    vt[4] = '{4'b1111, 4'b1011, 4'b1000};
    vt[5] = '{4'b0101, 4'b1110, 4'b0100};
    vt[6] = '{4'b0001, 4'b1111, 4'b0001};
    vt[7] = '{4'b0011, 4'b0001, 4'b0001};
    vt[8] = '{4'b1100, 4'b1111, 4'b0100};
    for (int v = 0; v < 9; v++) begin
      port_enable = vt[v].emask;
      w = 0;
      for (int p = 0; p < NP; p++) begin
        if (vt[v].vmask[p]) add_frame(p, 1, 16'(16'hA000 | (p << 4) | v));
        if (vt[v].gnt[p]) w = p;
      end
      expect_frame(1, 16'(16'hA000 | (w << 4) | v), vt[v].gnt);
      drive_ports();
      n = 0;
      do begin
        step();
        n++;
      end while (grant == '0 && n < 10);
      chk("vec_grant", grant, vt[v].gnt);
      for (int p = 0; p < NP; p++) if (!grant[p]) pq[p].delete();
      drive_ports();
      wait_done("vec_drain", 10, 1);
    end
    port_enable = '1;

    count_clear = 1'b1;
    step();
    count_clear = 1'b0;
    chk("clear_all", pkt_count, 0);

    // Full rotation with back-to-back 2-beat frames on every port.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int f = 0; f < 2; f++)
      for (int p = 0; p < NP; p++) begin
        add_frame(p, 2, 16'(16'h2000 | (p << 8) | (f << 4)));
        expect_frame(2, 16'(16'h2000 | (p << 8) | (f << 4)), 4'(1 << p));
      end
    drive_ports();
    wait_done("t2_drain", 80, 1);
    for (int p = 0; p < NP; p++) chk("t2_count", cnt(p), 2);

    // Runaway frame: truncated at beat 768, tail dropped until its tlast.
    trunc_cnt = 0;
    eg_cnt = 0;
    for (int i = 0; i < 800; i++) pq[1].push_back({(i == 799), 16'(i)});
    for (int i = 0; i < MAXB; i++) exp_q.push_back('{gnt: 4'b0010, last: (i == MAXB - 1), data: 16'(i)});
    drive_ports();
    wait_done("t3_drain", 900, 1);
    chk("t3_trunc_cycles", trunc_cnt, 1);
    chk("t3_egress_beats", eg_cnt, MAXB);
    chk("t3_count1", cnt(1), 2);

    // Egress backpressure in the middle of a frame.
    eg_cnt = 0;
    mirror_chk = 1'b1;
    add_frame(3, 4, 16'h4000);
    expect_frame(4, 16'h4000, 4'b1000);
    rdy_q.push_back(1'b1);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b0);
    rdy_q.push_back(1'b1);
    drive_ports();
    wait_done("t4_drain", 20, 1);
    mirror_chk = 1'b0;
    chk("t4_egress_beats", eg_cnt, 4);
    chk("t4_count3", cnt(3), 3);

    // Enable dropped mid-frame: frame finishes, next arbitration skips port 1.
    eg_cnt = 0;
    add_frame(1, 4, 16'h5100);
    add_frame(1, 2, 16'h5110);
    add_frame(2, 2, 16'h5200);
    expect_frame(4, 16'h5100, 4'b0010);
    expect_frame(2, 16'h5200, 4'b0100);
    drive_ports();
    n = 0;
    while (eg_cnt < 2 && n < 20) begin
      step();
      n++;
    end
    port_enable[1] = 1'b0;
    wait_done("t5_drain", 30, 0);
    repeat (3) step();
    chk("t5_skip_grant", grant, 0);
    chk("t5_pending", pq[1].size(), 2);
    port_enable[1] = 1'b1;
    expect_frame(2, 16'h5110, 4'b0010);
    wait_done("t5_resume", 20, 1);
    chk("t5_count1", cnt(1), 4);

    // count_clear on the tlast handshake cycle wins over the increment.
    add_frame(0, 2, 16'h6000);
    expect_frame(2, 16'h6000, 4'b0001);
    drive_ports();
    wait_done("t6_pre_drain", 20, 1);
    chk("t6_pre_count0", cnt(0), 3);
    add_frame(0, 2, 16'h6010);
    expect_frame(2, 16'h6010, 4'b0001);
    drive_ports();
    n = 0;
    while (!(grant == 4'b0001 && pq[0].size() == 1 && eg_snk.tready) && n < 20) begin
      step();
      n++;
    end
    count_clear = 1'b1;
    step();
    count_clear = 1'b0;
    chk("t6_clear_prio", cnt(0), 0);
    wait_done("t6_drain", 20, 1);

    // Reset in the middle of a frame abandons it at once.
    eg_cnt = 0;
    add_frame(2, 6, 16'h6200);
    expect_frame(6, 16'h6200, 4'b0100);
    drive_ports();
    n = 0;
    while (eg_cnt < 2 && n < 20) begin
      step();
      n++;
    end
    reset = 1'b1;
    step();
    chk("t6_rst_grant", grant, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_in_tready", snk, 0);
    chk("t6_rst_eg_valid", eg_src.tvalid, 0);
    reset = 1'b0;
    pq[2].delete();
    exp_q.delete();
    drive_ports();
    repeat (2) step();
    chk("t6_post_grant", grant, 0);
    chk("t6_post_count", pkt_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
